instr_loader: RTL and testbench

- Boot-time loader that writes the program into the single-cycle CPU's instruction memory, replacing file preload.
- Receives a byte stream over a valid/ready link, assembles little-endian 32-bit words and writes them to consecutive word-aligned addresses.
- Verifies a trailing XOR checksum, zero-fills the rest of memory so that end-of-program detection on an all-zero instruction works, then releases the CPU from reset.

---
 rtl/instr_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_instr_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot loader for the instruction memory: takes a counted byte stream, writes
// little-endian words, checks an XOR checksum, zero-fills the rest, releases the CPU.
module instr_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic             im_we_o,
    output logic [31:0]      im_addr_o,
    output logic [31:0]      im_data_o,
    output logic             cpu_rst_n_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_o
);

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_FILL  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam logic [7:0]       DEPTH_B  = 8'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_W  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_W    = CNT_W'(1);

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
        return {{(30-CNT_W){1'b0}}, idx, 2'b00};
    endfunction

    function automatic logic [31:0] asm_insert(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = word;
        endcase
        return r;
    endfunction

    state_t           state_r,     state_s;
    logic [CNT_W-1:0] n_r,         n_s;
    logic [CNT_W-1:0] words_r,     words_s;
    logic [CNT_W-1:0] fill_idx_r,  fill_idx_s;
    logic [1:0]       byte_idx_r,  byte_idx_s;
    logic [31:0]      asm_r,       asm_s;
    logic [7:0]       acc_r,       acc_s;
    logic             rx_ready_r,  rx_ready_s;
    logic             im_we_r,     im_we_s;
    logic [31:0]      im_addr_r,   im_addr_s;
    logic [31:0]      im_data_r,   im_data_s;
    logic             cpu_rst_n_r, cpu_rst_n_s;
    logic             done_r,      done_s;
    logic             err_r,       err_s;
    logic             xfer_s;

    assign xfer_s = rx_valid_i & rx_ready_r;

    // Next-state and next-output decode; outputs are computed one edge ahead so they leave registers
    always_comb begin
        state_s     = state_r;
        n_s         = n_r;
        words_s     = words_r;
        fill_idx_s  = fill_idx_r;
        byte_idx_s  = byte_idx_r;
        asm_s       = asm_r;
        acc_s       = acc_r;
        rx_ready_s  = rx_ready_r;
        im_we_s     = 1'b0;
        im_addr_s   = im_addr_r;
        im_data_s   = im_data_r;
        cpu_rst_n_s = cpu_rst_n_r;
        done_s      = done_r;
        err_s       = err_r;
        case (state_r)
            ST_COUNT: begin
                rx_ready_s = 1'b1;
                if (xfer_s) begin
                    n_s = rx_data_i[CNT_W-1:0];
                    if (rx_data_i > DEPTH_B) begin
                        state_s     = ST_ERR;
                        err_s       = 1'b1;
                        cpu_rst_n_s = 1'b0;
                        rx_ready_s  = 1'b0;
                    end else if (rx_data_i == 8'd0) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_COUNT;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    acc_s      = csum_step(acc_r, rx_data_i);
                    byte_idx_s = byte_idx_r + 2'd1;
                    asm_s      = asm_insert(asm_r, byte_idx_r, rx_data_i);
                    if (byte_idx_r == 2'd3) begin
                        // The word is complete: present it for exactly one cycle and stall the link
                        state_s    = ST_WRITE;
                        im_we_s    = 1'b1;
                        im_addr_s  = word_addr(words_r);
                        im_data_s  = asm_insert(asm_r, 2'd3, rx_data_i);
                        rx_ready_s = 1'b0;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                words_s    = words_r + ONE_W;
                rx_ready_s = 1'b1;
                if ((words_r + ONE_W) == n_r) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (xfer_s) begin
                    rx_ready_s = 1'b0;
                    if (rx_data_i != acc_r) begin
                        state_s = ST_ERR;
                        err_s   = 1'b1;
                    end else if (n_r < DEPTH_W) begin
                        state_s    = ST_FILL;
                        fill_idx_s = n_r;
                        im_we_s    = 1'b1;
                        im_addr_s  = word_addr(n_r);
                        im_data_s  = 32'h0000_0000;
                    end else begin
                        state_s     = ST_DONE;
                        done_s      = 1'b1;
                        cpu_rst_n_s = 1'b1;
                    end
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_FILL: begin
                if (fill_idx_r == LAST_IDX) begin
                    state_s     = ST_DONE;
                    done_s      = 1'b1;
                    cpu_rst_n_s = 1'b1;
                end else begin
                    fill_idx_s = fill_idx_r + ONE_W;
                    im_we_s    = 1'b1;
                    im_addr_s  = word_addr(fill_idx_r + ONE_W);
                    im_data_s  = 32'h0000_0000;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start_i) begin
                    // Re-hold the CPU on the same edge that re-arms the loader
                    state_s     = ST_COUNT;
                    n_s         = {CNT_W{1'b0}};
                    words_s     = {CNT_W{1'b0}};
                    byte_idx_s  = 2'd0;
                    asm_s       = 32'h0000_0000;
                    acc_s       = 8'h00;
                    rx_ready_s  = 1'b1;
                    cpu_rst_n_s = 1'b0;
                    done_s      = 1'b0;
                    err_s       = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s     = ST_COUNT;
                rx_ready_s  = 1'b1;
                cpu_rst_n_s = 1'b0;
                done_s      = 1'b0;
                err_s       = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_COUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_r         <= {CNT_W{1'b0}};
            words_r     <= {CNT_W{1'b0}};
            fill_idx_r  <= {CNT_W{1'b0}};
            byte_idx_r  <= 2'd0;
            asm_r       <= 32'h0000_0000;
            acc_r       <= 8'h00;
            rx_ready_r  <= 1'b1;
            im_we_r     <= 1'b0;
            im_addr_r   <= 32'h0000_0000;
            im_data_r   <= 32'h0000_0000;
            cpu_rst_n_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            n_r         <= n_s;
            words_r     <= words_s;
            fill_idx_r  <= fill_idx_s;
            byte_idx_r  <= byte_idx_s;
            asm_r       <= asm_s;
            acc_r       <= acc_s;
            rx_ready_r  <= rx_ready_s;
            im_we_r     <= im_we_s;
            im_addr_r   <= im_addr_s;
            im_data_r   <= im_data_s;
            cpu_rst_n_r <= cpu_rst_n_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign rx_ready_o  = rx_ready_r;
    assign im_we_o     = im_we_r;
    assign im_addr_o   = im_addr_r;
    assign im_data_o   = im_data_r;
    assign cpu_rst_n_o = cpu_rst_n_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign words_o     = words_r;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: table of load cases, hand-written corner sequences and
// random streams, all checked against a stream-level reference model.
module tb_instr_loader;

    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready_o;
    logic             im_we_o;
    logic [31:0]      im_addr_o;
    logic [31:0]      im_data_o;
    logic             cpu_rst_n_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] words_o;

    instr_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready_o),
        .im_we_o     (im_we_o),
        .im_addr_o   (im_addr_o),
        .im_data_o   (im_data_o),
        .cpu_rst_n_o (cpu_rst_n_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int n; logic [7:0] corrupt; bit e_done; bit e_err; int e_words; int e_nwr; } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] strm[$];
    wr_t        got_q[$];
    wr_t        exp_q[$];
    bit         exp_done;
    bit         exp_err;
    int         exp_words;
    vec_t       vecs[10];

    // Capture every memory write away from the active edge
    always @(negedge clk) begin
        if (im_we_o === 1'b1) got_q.push_back('{im_addr_o, im_data_o});
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: what a stream should do to memory and status, from the stream format alone
    function automatic void build_model();
        int         n;
        logic [7:0] cs;
        exp_q.delete();
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        n  = int'(strm[0]);
        cs = 8'h00;
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{32'(4*i), {strm[4*i+4], strm[4*i+3], strm[4*i+2], strm[4*i+1]}});
            cs = cs ^ strm[4*i+1] ^ strm[4*i+2] ^ strm[4*i+3] ^ strm[4*i+4];
        end
        exp_words = n;
        if (strm[4*n+1] != cs) begin
            exp_err = 1'b1;
            return;
        end
        for (int a = n; a < DEPTH; a++) exp_q.push_back('{32'(4*a), 32'h0});
        exp_done = 1'b1;
    endfunction

    task automatic make_stream(input int n, input logic [7:0] corrupt);
        logic [7:0] b;
        logic [7:0] cs;
        strm.delete();
        cs = 8'h00;
        strm.push_back(8'(n));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4*n; i++) begin
                b  = 8'($urandom);
                cs = cs ^ b;
                strm.push_back(b);
            end
            strm.push_back(cs ^ corrupt);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int guard;
        gap      = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        guard    = 0;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("rx_ready_timeout", 64'(guard), 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input int max_gap);
        for (int i = 0; i < strm.size(); i++) send_byte(strm[i], max_gap);
    endtask

    task automatic finish_check(input int max_wait);
        int guard;
        int n;
        guard = 0;
        while (!(done_o || err_o) && guard < max_wait) begin
            @(negedge clk);
            guard++;
        end
        check("end_reached", 64'(guard < max_wait), 64'd1);
        @(negedge clk);
        check("done", 64'(done_o), 64'(exp_done));
        check("err", 64'(err_o), 64'(exp_err));
        check("cpu_rst_n", 64'(cpu_rst_n_o), 64'(exp_done));
        check("rx_ready_idle", 64'(rx_ready_o), 64'd0);
        check("words", 64'(words_o), 64'(exp_words));
        check("nwrites", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("wr_addr", 64'(got_q[i].addr), 64'(exp_q[i].addr));
            check("wr_data", 64'(got_q[i].data), 64'(exp_q[i].data));
        end
    endtask

    task automatic run_load(input int max_gap);
        got_q.delete();
        build_model();
        send_stream(max_gap);
        finish_check(600);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_cpu_rst_n", 64'(cpu_rst_n_o), 64'd0);
        check("start_done", 64'(done_o), 64'd0);
        check("start_err", 64'(err_o), 64'd0);
        check("start_words", 64'(words_o), 64'd0);
        check("start_rx_ready", 64'(rx_ready_o), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready_o), 64'd1);
        check({tag, "_we"}, 64'(im_we_o), 64'd0);
        check({tag, "_addr"}, 64'(im_addr_o), 64'd0);
        check({tag, "_data"}, 64'(im_data_o), 64'd0);
        check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
        check({tag, "_words"}, 64'(words_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        vecs[0] = '{2,   8'h00, 1'b1, 1'b0, 2,  32};
        vecs[1] = '{2,   8'h01, 1'b0, 1'b1, 2,  2};
        vecs[2] = '{33,  8'h00, 1'b0, 1'b1, 0,  0};
        vecs[3] = '{0,   8'h00, 1'b1, 1'b0, 0,  32};
        vecs[4] = '{0,   8'h80, 1'b0, 1'b1, 0,  0};
        vecs[5] = '{32,  8'h00, 1'b1, 1'b0, 32, 32};
        vecs[6] = '{32,  8'h10, 1'b0, 1'b1, 32, 32};
        vecs[7] = '{1,   8'h00, 1'b1, 1'b0, 1,  32};
        vecs[8] = '{31,  8'h00, 1'b1, 1'b0, 31, 32};
        vecs[9] = '{255, 8'h00, 1'b0, 1'b1, 0,  0};

        #22;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Two-word program with the known-good checksum
        strm = '{8'h02, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h08, 8'h01, 8'h44};
        run_load(0);
        check("s1_nwr", 64'(got_q.size()), 64'd32);
        if (got_q.size() >= 3) begin
            check("s1_w0_addr", 64'(got_q[0].addr), 64'h0);
            check("s1_w0_data", 64'(got_q[0].data), 64'h2008_0005);
            check("s1_w1_addr", 64'(got_q[1].addr), 64'h4);
            check("s1_w1_data", 64'(got_q[1].data), 64'h0108_4020);
            check("s1_fill_first", 64'(got_q[2].addr), 64'h8);
            check("s1_fill_last", 64'(got_q[got_q.size()-1].addr), 64'd124);
        end
        check("s1_done", 64'(done_o), 64'd1);
        check("s1_words", 64'(words_o), 64'd2);

        // Same program with a bad checksum
        do_start();
        strm = '{8'h02, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h08, 8'h01, 8'h45};
        run_load(0);
        check("badcs_err", 64'(err_o), 64'd1);
        check("badcs_nwr", 64'(got_q.size()), 64'd2);

        // Oversize count errors on the count byte's own edge
        do_start();
        got_q.delete();
        send_byte(8'd33, 0);
        check("oversize_err_now", 64'(err_o), 64'd1);
        check("oversize_nwr", 64'(got_q.size()), 64'd0);

        // Valid held high through the write cycle: the byte waits for ready
        do_start();
        strm = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        got_q.delete();
        build_model();
        for (int i = 0; i < 5; i++) send_byte(strm[i], 0);
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        check("bp_ready_low", 64'(rx_ready_o), 64'd0);
        check("bp_we", 64'(im_we_o), 64'd1);
        check("bp_data", 64'(im_data_o), 64'h4433_2211);
        @(negedge clk);
        check("bp_ready_back", 64'(rx_ready_o), 64'd1);
        check("bp_words", 64'(words_o), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        finish_check(600);

        // Table of load shapes, each started fresh
        for (int v = 0; v < 10; v++) begin
            do_start();
            make_stream(vecs[v].n, vecs[v].corrupt);
            run_load(1);
            check("tbl_done", 64'(done_o), 64'(vecs[v].e_done));
            check("tbl_err", 64'(err_o), 64'(vecs[v].e_err));
            check("tbl_words", 64'(words_o), 64'(vecs[v].e_words));
            check("tbl_nwr", 64'(got_q.size()), 64'(vecs[v].e_nwr));
        end

        // Scenario one again with random valid gaps
        do_start();
        strm = '{8'h02, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h08, 8'h01, 8'h44};
        run_load(3);

        // Random programs, gaps and occasional corruption
        for (int r = 0; r < 8; r++) begin
            do_start();
            make_stream(int'($urandom_range(34, 0)), ($urandom_range(3, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00);
            run_load(3);
        end

        // Reset in the middle of a load, then a fresh load after release
        do_start();
        strm = '{8'h02, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h08, 8'h01, 8'h44};
        for (int i = 0; i < 7; i++) send_byte(strm[i], 0);
        check("midrst_words_before", 64'(words_o), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_load(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
